jp_emu: RTL and testbench

JP_EMU -- requirements
Module: jp_emu

---
 rtl/jp_emu_pkg.sv | 55 +++++
 rtl/jp_sync.sv | 41 ++++
 rtl/jp_emu.sv | 134 +++++++++++++
 tb/tb_jp_emu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jp_emu_pkg.sv
// -----------------------------------------------------------------------------
// jp_emu_pkg
// Shared joypad definitions, used by the pad emulator (jp_emu) and by the
// joypad controller block that drives its shift clock and latch.
//   - Button bit positions inside the 8-bit button byte (active-high pressed).
//   - Shift index width and its saturation value (one past the last button).
//   - Per-pad register bundle and the serial-bit helper.
// -----------------------------------------------------------------------------
package jp_emu_pkg;

  localparam int unsigned JP_BTN_W = 8;
  localparam int unsigned JP_IDX_W = 4;
  localparam int unsigned JP_PADS  = 2;
  localparam int unsigned JP_CNT_W = 16;

  // Button bit positions, in the order they are shifted out.
  localparam int unsigned JP_BTN_A      = 0;
  localparam int unsigned JP_BTN_B      = 1;
  localparam int unsigned JP_BTN_SELECT = 2;
  localparam int unsigned JP_BTN_START  = 3;
  localparam int unsigned JP_BTN_UP     = 4;
  localparam int unsigned JP_BTN_DOWN   = 5;
  localparam int unsigned JP_BTN_LEFT   = 6;
  localparam int unsigned JP_BTN_RIGHT  = 7;

  // Shift index saturates here; the serial line then reads as "all ones"
  // to the CPU (driven low on the active-low line).
  localparam logic [JP_IDX_W-1:0] JP_IDX_MAX = 4'd8;

  typedef enum logic {
    PAD1 = 1'b0,
    PAD2 = 1'b1
  } jp_pad_e;

  typedef logic [JP_BTN_W-1:0] jp_btn_t;

  // pending : last accepted host update, waiting for the next latch
  // pend_full: pending holds an update not yet moved to shadow
  // shadow  : button byte being shifted out in the current frame
  typedef struct packed {
    jp_btn_t pending;
    logic    pend_full;
    jp_btn_t shadow;
  } jp_pad_state_t;

  // Active-low serial level for a given shift index.
  function automatic logic jp_serial_bit(input jp_btn_t            sh,
                                         input logic [JP_IDX_W-1:0] idx);
    if (idx >= JP_IDX_MAX) begin
      return 1'b0;
    end
    return ~sh[idx[2:0]];
  endfunction

endpackage

// File: rtl/jp_sync.sv
// -----------------------------------------------------------------------------
// jp_sync
// Two-flop synchronizer for one asynchronous control line, plus a third flop
// that turns the synchronized level into a single-cycle rising-edge pulse.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset (all flops to 0)
//   async_i : asynchronous input line
//   level_o : synchronized level
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module jp_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: non-blocking assignments let each flop sample the previous stage's
  // old value, which is what makes this a shift chain rather than a wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/jp_emu.sv
// -----------------------------------------------------------------------------
// jp_emu
// Emulates two serial game pads. The host posts button bytes through a
// valid/ready handshake; each pad buffers one update and moves it into its
// shadow register on the next controller latch. The controller then clocks
// the shadow out one bit per shift clock on an active-low serial line.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   jp_clk, jp_latch  : controller shift clock / latch (asynchronous to clk)
//   btn_valid/ready   : host update handshake
//   btn_sel           : pad addressed by the update (0 = pad1, 1 = pad2)
//   btn_data          : button byte, active-high pressed
//   jp_data1/2        : registered active-low serial lines
//   poll_cnt          : number of latch rising edges seen, wrapping
// -----------------------------------------------------------------------------
module jp_emu
  import jp_emu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                jp_clk,
  input  logic                jp_latch,
  input  logic                btn_valid,
  input  logic                btn_sel,
  input  logic [JP_BTN_W-1:0] btn_data,
  output logic                btn_ready,
  output logic                jp_data1,
  output logic                jp_data2,
  output logic [JP_CNT_W-1:0] poll_cnt
);

  logic latch_lvl;
  logic latch_rise;
  logic clk_rise;
  logic unused_clk_lvl;  // only the shift clock's rising edge matters

  jp_sync u_sync_latch (
    .clk     (clk),
    .rst     (rst),
    .async_i (jp_latch),
    .level_o (latch_lvl),
    .rise_o  (latch_rise)
  );

  jp_sync u_sync_clk (
    .clk     (clk),
    .rst     (rst),
    .async_i (jp_clk),
    .level_o (unused_clk_lvl),
    .rise_o  (clk_rise)
  );

  jp_pad_state_t [JP_PADS-1:0] pad_q, pad_d;
  logic [JP_IDX_W-1:0]         idx_q, idx_d;
  logic [JP_CNT_W-1:0]         poll_q, poll_d;
  logic [JP_PADS-1:0]          data_q, data_d;

  logic               handshake;
  logic [JP_PADS-1:0] hs_pad;

  // A pad accepts a new update only once its previous one has been latched.
  assign btn_ready = ~pad_q[btn_sel].pend_full;
  assign handshake = btn_valid & btn_ready;
  assign hs_pad    = {handshake & btn_sel, handshake & ~btn_sel};

  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pad_d = pad_q;
    for (int p = 0; p < JP_PADS; p++) begin
      if (latch_rise) begin
        if (hs_pad[p]) begin
          // Update arriving on the latch edge itself goes straight to shadow,
          // so it is neither lost nor delayed by a whole frame.
          pad_d[p].shadow    = btn_data;
          pad_d[p].pend_full = 1'b0;
        end else if (pad_q[p].pend_full) begin
          pad_d[p].shadow    = pad_q[p].pending;
          pad_d[p].pend_full = 1'b0;
        end
      end else if (hs_pad[p]) begin
        pad_d[p].pending   = btn_data;
        pad_d[p].pend_full = 1'b1;
      end
    end
  end

  // Shift index: pinned to the first button while latched, otherwise steps
  // on each shift clock and stops one past the last button.
  always_comb begin
    idx_d = idx_q;
    if (latch_lvl) begin
      idx_d = '0;
    end else if (clk_rise && (idx_q < JP_IDX_MAX)) begin
      idx_d = idx_q + 4'd1;
    end
  end

  always_comb begin
    poll_d = poll_q;
    if (latch_rise) begin
      poll_d = poll_q + 16'd1;
    end
  end

  always_comb begin
    data_d = '0;
    for (int p = 0; p < JP_PADS; p++) begin
      data_d[p] = jp_serial_bit(pad_q[p].shadow, idx_q);
    end
  end

  // NOTE: the button registers are a handful of flops, not a RAM, so they
  // are reset along with the rest of the state; a reset mid-frame therefore
  // leaves nothing stale for the next latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_q  <= '0;
      idx_q  <= '0;
      poll_q <= '0;
      data_q <= '1;
    end else begin
      pad_q  <= pad_d;
      idx_q  <= idx_d;
      poll_q <= poll_d;
      data_q <= data_d;
    end
  end

  assign jp_data1 = data_q[0];
  assign jp_data2 = data_q[1];
  assign poll_cnt = poll_q;

endmodule

// File: tb/tb_jp_emu.sv
// -----------------------------------------------------------------------------
// tb_jp_emu
// Directed bench for jp_emu. Expected serial levels are pushed to a queue as
// each latch / shift-clock step is driven and popped when the outputs are
// sampled. The final part plays the joypad controller (strobe, then CPU reads
// that return the inverted serial line before each shift clock).
// -----------------------------------------------------------------------------
module tb_jp_emu;
  import jp_emu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        jp_clk;
  logic        jp_latch;
  logic        btn_valid;
  logic        btn_sel;
  logic [7:0]  btn_data;
  logic        btn_ready;
  logic        jp_data1;
  logic        jp_data2;
  logic [15:0] poll_cnt;

  always #5 clk = ~clk;

  jp_emu dut (
    .clk       (clk),
    .rst       (rst),
    .jp_clk    (jp_clk),
    .jp_latch  (jp_latch),
    .btn_valid (btn_valid),
    .btn_sel   (btn_sel),
    .btn_data  (btn_data),
    .btn_ready (btn_ready),
    .jp_data1  (jp_data1),
    .jp_data2  (jp_data2),
    .poll_cnt  (poll_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic d1;
    logic d2;
  } exp_t;
  exp_t sb_q[$];

  // Reference state of the emulated pads.
  logic [7:0]  m_pend   [2];
  logic [7:0]  m_shadow [2];
  logic        m_full   [2];
  int          m_idx;
  logic [15:0] m_poll;

  function automatic logic m_bit(input logic [7:0] sh, input int idx);
    return (idx < 8) ? ~sh[idx] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.d1 = m_bit(m_shadow[0], m_idx);
    e.d2 = m_bit(m_shadow[1], m_idx);
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_d1"}, {15'd0, jp_data1}, {15'd0, e.d1});
    check({tag, "_d2"}, {15'd0, jp_data2}, {15'd0, e.d2});
  endtask

  // Four clk edges after a raw control edge the output must be updated.
  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p]   = 8'h00;
      m_shadow[p] = 8'h00;
      m_full[p]   = 1'b0;
    end
    m_idx  = 0;
    m_poll = 16'h0000;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_btn(input logic sel, input logic [7:0] data, output logic acc);
    @(negedge clk);
    btn_sel   = sel;
    btn_data  = data;
    btn_valid = 1'b1;
    acc       = btn_ready;
    @(posedge clk);
    #1 btn_valid = 1'b0;
    if (acc) begin
      m_pend[sel] = data;
      m_full[sel] = 1'b1;
    end
  endtask

  task automatic model_latch_rise();
    m_poll = m_poll + 16'd1;
    for (int p = 0; p < 2; p++) begin
      if (m_full[p]) begin
        m_shadow[p] = m_pend[p];
        m_full[p]   = 1'b0;
      end
    end
    m_idx = 0;
  endtask

  task automatic latch_pulse();
    @(negedge clk);
    #2 jp_latch = 1'b1;
    settle();
    model_latch_rise();
    #2 jp_latch = 1'b0;
    settle();
    push_exp();
  endtask

  task automatic clk_pulse(input logic latched);
    #2 jp_clk = 1'b1;
    settle();
    #2 jp_clk = 1'b0;
    settle();
    if (!latched && m_idx < 8) m_idx++;
    push_exp();
  endtask

  task automatic ready_check(input string tag, input logic sel);
    @(negedge clk);
    btn_sel = sel;
    #1 check(tag, {15'd0, btn_ready}, 16'd1);
  endtask

  logic acc;
  logic cpu_rd;
  logic exp_reads [10];

  initial begin
    rst       = 1'b1;
    jp_clk    = 1'b0;
    jp_latch  = 1'b0;
    btn_valid = 1'b0;
    btn_sel   = 1'b0;
    btn_data  = 8'h00;
    model_reset();

    // ---- reset state ----
    do_reset();
    check("rst_d1", {15'd0, jp_data1}, 16'd1);
    check("rst_d2", {15'd0, jp_data2}, 16'd1);
    check("rst_poll", poll_cnt, 16'd0);
    ready_check("rst_ready1", PAD1);
    ready_check("rst_ready2", PAD2);

    // ---- readout of 0x81 on pad1 ----
    write_btn(PAD1, 8'h81, acc);
    check("rd_acc", {15'd0, acc}, 16'd1);
    latch_pulse();
    pop_check("rd_b0");
    for (int i = 1; i <= 8; i++) begin
      clk_pulse(1'b0);
      pop_check($sformatf("rd_clk%0d", i));
    end
    check("rd_poll", poll_cnt, m_poll);

    // ---- backpressure on pad2 ----
    write_btn(PAD2, 8'h0F, acc);
    check("bp_acc1", {15'd0, acc}, 16'd1);
    write_btn(PAD2, 8'h0F, acc);
    check("bp_stall", {15'd0, acc}, 16'd0);
    ready_check("bp_ready1_free", PAD1);
    latch_pulse();
    ready_check("bp_ready2_after", PAD2);
    pop_check("bp_b0");
    for (int i = 1; i <= 8; i++) begin
      clk_pulse(1'b0);
      pop_check($sformatf("bp_clk%0d", i));
    end

    // ---- handshake on the synchronized latch edge ----
    @(negedge clk);
    jp_latch = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn_sel   = PAD1;
    btn_data  = 8'h02;
    btn_valid = 1'b1;
    check("col_ready", {15'd0, btn_ready}, 16'd1);
    @(posedge clk);
    #1 btn_valid = 1'b0;
    model_latch_rise();
    m_shadow[0] = 8'h02;
    settle();
    jp_latch = 1'b0;
    settle();
    push_exp();
    pop_check("col_b0");
    ready_check("col_not_full", PAD1);
    clk_pulse(1'b0);
    pop_check("col_b1");
    check("col_poll", poll_cnt, m_poll);

    // ---- shift clocks ignored while latched ----
    @(negedge clk);
    #2 jp_latch = 1'b1;
    settle();
    model_latch_rise();
    for (int i = 0; i < 3; i++) begin
      clk_pulse(1'b1);
      pop_check($sformatf("hold_clk%0d", i));
    end
    #2 jp_latch = 1'b0;
    settle();
    push_exp();
    pop_check("hold_release");
    clk_pulse(1'b0);
    pop_check("hold_b1");

    // ---- reset mid-frame, then a clean frame ----
    write_btn(PAD1, 8'h3C, acc);
    latch_pulse();
    pop_check("mid_b0");
    for (int i = 1; i <= 3; i++) begin
      clk_pulse(1'b0);
      pop_check($sformatf("mid_clk%0d", i));
    end
    do_reset();
    check("mid_rst_d1", {15'd0, jp_data1}, 16'd1);
    check("mid_rst_d2", {15'd0, jp_data2}, 16'd1);
    check("mid_rst_poll", poll_cnt, 16'd0);
    write_btn(PAD1, 8'h5A, acc);
    latch_pulse();
    pop_check("clean_b0");
    for (int i = 1; i <= 8; i++) begin
      clk_pulse(1'b0);
      pop_check($sformatf("clean_clk%0d", i));
    end
    check("clean_poll", poll_cnt, 16'd1);

    // ---- controller-style strobe and CPU reads of 0xA5 ----
    exp_reads = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    write_btn(PAD1, 8'hA5, acc);
    latch_pulse();
    void'(sb_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      cpu_rd = ~jp_data1;
      check($sformatf("cpu_read%0d", i), {15'd0, cpu_rd}, {15'd0, exp_reads[i]});
      clk_pulse(1'b0);
      pop_check($sformatf("cpu_clk%0d", i));
    end
    check("cpu_poll", poll_cnt, m_poll);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
